// File: rtl/nfca_tx_crc_append.sv
// NFC-A transmit framer: forwards bytes through one registered slot and appends CRC_A.
// Optional macro NFCA_ANTICOLL_AUTO_EN suppresses the CRC on incomplete anticollision frames.
module nfca_tx_crc_append (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_tvalid,
  output logic       s_tready,
  input  logic [7:0] s_tdata,
  input  logic [3:0] s_tdatab,
  input  logic       s_tlast,
  input  logic       s_crc_en,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic [7:0] m_tdata,
  output logic [3:0] m_tdatab,
  output logic       m_tlast
);

  localparam logic [1:0]  ST_DATA   = 2'd0;
  localparam logic [1:0]  ST_CRC_LO = 2'd1;
  localparam logic [1:0]  ST_CRC_HI = 2'd2;
  localparam logic [15:0] CRC_INIT  = 16'h6363;

  logic [1:0]  state_q, state_d;
  logic        m_tvalid_q, m_tvalid_d;
  logic [7:0]  m_tdata_q, m_tdata_d;
  logic [3:0]  m_tdatab_q, m_tdatab_d;
  logic        m_tlast_q, m_tlast_d;
  logic [15:0] crc_q, crc_d;
  logic        crc_en_q, crc_en_d;
  logic        first_q, first_d;

  logic        slot_free, accept, crc_en_eff, append, frame_done, suppress;
  logic [15:0] crc_upd;

  assign slot_free = !m_tvalid_q || m_tready;
  assign s_tready  = (state_q == ST_DATA) && slot_free;
  assign accept    = s_tvalid && s_tready;

  assign m_tvalid = m_tvalid_q;
  assign m_tdata  = m_tdata_q;
  assign m_tdatab = m_tdatab_q;
  assign m_tlast  = m_tlast_q;

  // Byte-wide CRC_A step, LSB first with the reflected polynomial.
  always_comb begin
    crc_upd = crc_q ^ {8'h00, s_tdata};
    for (int unsigned i = 0; i < 8; i++) begin
      crc_upd = crc_upd[0] ? ({1'b0, crc_upd[15:1]} ^ 16'h8408) : {1'b0, crc_upd[15:1]};
    end
  end

`ifdef NFCA_ANTICOLL_AUTO_EN
  logic sel_q, sel_d, second_q, second_d, nvb_bad_q, nvb_bad_d;

  // A single-byte frame never suppresses; the NVB may be the current byte or an earlier one.
  always_comb begin
    if (first_q)       suppress = 1'b0;
    else if (second_q) suppress = sel_q && (s_tdata != 8'h70);
    else               suppress = sel_q && nvb_bad_q;
  end

  always_comb begin
    sel_d     = sel_q;
    second_d  = second_q;
    nvb_bad_d = nvb_bad_q;
    if (frame_done) begin
      sel_d     = 1'b0;
      second_d  = 1'b0;
      nvb_bad_d = 1'b0;
    end else if (accept) begin
      if (first_q) begin
        sel_d    = (s_tdata == 8'h93) || (s_tdata == 8'h95) || (s_tdata == 8'h97);
        second_d = 1'b1;
      end else if (second_q) begin
        nvb_bad_d = (s_tdata != 8'h70);
        second_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q     <= 1'b0;
      second_q  <= 1'b0;
      nvb_bad_q <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      second_q  <= second_d;
      nvb_bad_q <= nvb_bad_d;
    end
  end
`else
  assign suppress = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tdatab_d = m_tdatab_q;
    m_tlast_d  = m_tlast_q;
    crc_d      = crc_q;
    crc_en_d   = crc_en_q;
    first_d    = first_q;
    frame_done = 1'b0;
    append     = 1'b0;
    crc_en_eff = first_q ? s_crc_en : crc_en_q;

    case (state_q)
      ST_DATA: begin
        if (accept) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = s_tdata;
          m_tdatab_d = s_tdatab;
          crc_d      = crc_upd;
          crc_en_d   = crc_en_eff;
          first_d    = 1'b0;
          append     = s_tlast && crc_en_eff && (s_tdatab == 4'd8) && !suppress;
          m_tlast_d  = s_tlast && !append;
          if (s_tlast) begin
            if (append) state_d = ST_CRC_LO;
            else        frame_done = 1'b1;
          end
        end else if (slot_free) begin
          m_tvalid_d = 1'b0;
        end
      end
      ST_CRC_LO: begin
        if (slot_free) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = crc_q[7:0];
          m_tdatab_d = 4'd8;
          m_tlast_d  = 1'b0;
          state_d    = ST_CRC_HI;
        end
      end
      ST_CRC_HI: begin
        if (slot_free) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = crc_q[15:8];
          m_tdatab_d = 4'd8;
          m_tlast_d  = 1'b1;
          state_d    = ST_DATA;
          frame_done = 1'b1;
        end
      end
      default: state_d = ST_DATA;
    endcase

    if (frame_done) begin
      crc_d    = CRC_INIT;
      crc_en_d = 1'b0;
      first_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_DATA;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tdatab_q <= '0;
      m_tlast_q  <= 1'b0;
      crc_q      <= CRC_INIT;
      crc_en_q   <= 1'b0;
      first_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tdatab_q <= m_tdatab_d;
      m_tlast_q  <= m_tlast_d;
      crc_q      <= crc_d;
      crc_en_q   <= crc_en_d;
      first_q    <= first_d;
    end
  end

endmodule

// File: tb/tb_nfca_tx_crc_append.sv
// Directed bench for nfca_tx_crc_append: table of frames with expected output streams,
// plus a hand-written reset-during-CRC sequence.
module tb_nfca_tx_crc_append;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_tvalid, s_tready, s_tlast, s_crc_en;
  logic [7:0] s_tdata;
  logic [3:0] s_tdatab;
  logic       m_tvalid, m_tready, m_tlast;
  logic [7:0] m_tdata;
  logic [3:0] m_tdatab;

  int unsigned tests = 0;
  int unsigned fails = 0;

  nfca_tx_crc_append dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tdatab(s_tdatab), .s_tlast(s_tlast), .s_crc_en(s_crc_en),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tdatab(m_tdatab), .m_tlast(m_tlast)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][7:0] b;
    int unsigned     n;
    logic [3:0]      db;
    logic            en;
    int unsigned     tmode;
    int unsigned     n_out;
    logic [5:0][7:0] exp;
  } vec_t;

  logic [3:0][7:0] in_b;
  int unsigned     in_n;
  logic [3:0]      in_db;
  logic            in_en;
  int unsigned     tready_mode;
  logic [7:0]      out_d[$];
  logic [3:0]      out_db[$];
  logic            out_l[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bit-serial reference CRC_A (input bit folded into the feedback).
  function automatic logic [15:0] crc_model(input logic [3:0][7:0] b, input int unsigned n);
    logic [15:0] c;
    logic        fb;
    c = 16'h6363;
    for (int unsigned i = 0; i < n; i++) begin
      for (int unsigned j = 0; j < 8; j++) begin
        fb = c[0] ^ b[i][j];
        c  = {1'b0, c[15:1]};
        if (fb) c = c ^ 16'h8408;
      end
    end
    return c;
  endfunction

  function automatic vec_t mk(input logic [31:0] bytes_in, input int unsigned n, input logic [3:0] db,
                              input logic en, input int unsigned tmode, input logic app);
    vec_t v;
    logic [15:0] c;
    v.b = bytes_in; v.n = n; v.db = db; v.en = en; v.tmode = tmode;
    v.n_out = app ? n + 2 : n;
    v.exp = '0;
    for (int unsigned i = 0; i < n; i++) v.exp[i] = v.b[i];
    if (app) begin
      c = crc_model(v.b, n);
      v.exp[n]   = c[7:0];
      v.exp[n+1] = c[15:8];
    end
    return v;
  endfunction

  task automatic drive_frame();
    logic ok;
    int unsigned guard;
    for (int unsigned i = 0; i < in_n; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = in_b[i];
      s_tlast  = (i == in_n - 1);
      s_tdatab = (i == in_n - 1) ? in_db : 4'd8;
      s_crc_en = (i == 0) ? in_en : 1'b0;
      guard = 0;
      do begin
        @(negedge clk); ok = s_tready;
        @(posedge clk); #1; guard++;
      end while (!ok && guard < 200);
      if (!ok) begin
        tests++; fails++;
        $display("FAIL drive_timeout: byte %0d never accepted", i);
      end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; s_crc_en = 1'b0;
  endtask

  task automatic collect();
    logic done, stalled;
    logic [7:0] hd;
    logic [3:0] hdb;
    logic hl;
    int unsigned cyc;
    done = 1'b0; stalled = 1'b0; cyc = 0; hd = '0; hdb = '0; hl = 1'b0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      if (stalled) chk("hold_stable", {m_tvalid, m_tlast, m_tdatab, m_tdata}, {1'b1, hl, hdb, hd});
      if (m_tvalid && m_tready) begin
        out_d.push_back(m_tdata); out_db.push_back(m_tdatab); out_l.push_back(m_tlast);
        if (m_tlast) done = 1'b1;
      end
      stalled = m_tvalid && !m_tready;
      hd = m_tdata; hdb = m_tdatab; hl = m_tlast;
      @(posedge clk); #1;
      if (tready_mode == 1) m_tready = ~m_tready;
      cyc++;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL collect_timeout: got %0d bytes, no tlast", out_d.size());
    end
    m_tready = 1'b1;
  endtask

  task automatic run_vec(input int unsigned idx, input vec_t v);
    logic [3:0] edb;
    in_b = v.b; in_n = v.n; in_db = v.db; in_en = v.en;
    tready_mode = v.tmode; m_tready = 1'b1;
    out_d.delete(); out_db.delete(); out_l.delete();
    fork
      drive_frame();
      collect();
    join
    chk($sformatf("v%0d_count", idx), out_d.size(), v.n_out);
    for (int unsigned k = 0; k < v.n_out && k < out_d.size(); k++) begin
      edb = (k == v.n - 1) ? v.db : 4'd8;
      chk($sformatf("v%0d_b%0d_data", idx, k), out_d[k], v.exp[k]);
      chk($sformatf("v%0d_b%0d_datab", idx, k), out_db[k], edb);
      chk($sformatf("v%0d_b%0d_tlast", idx, k), out_l[k], k == v.n_out - 1);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  vec_t vecs[11];
  vec_t v;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(32'h0000_0026, 1, 4'd7, 1'b1, 0, 1'b0);
    vecs[1]  = mk(32'h0000_0050, 2, 4'd8, 1'b1, 0, 1'b1);
    vecs[1].exp[2] = 8'h57; vecs[1].exp[3] = 8'hCD;
    vecs[2]  = mk(32'h0000_50E0, 2, 4'd8, 1'b1, 0, 1'b1);
    vecs[2].exp[2] = 8'hBC; vecs[2].exp[3] = 8'hA5;
    vecs[3]  = mk(32'h0000_0000, 2, 4'd8, 1'b1, 1, 1'b1);
    vecs[3].exp[2] = 8'hA0; vecs[3].exp[3] = 8'h1E;
    vecs[4]  = mk(32'h0000_0050, 2, 4'd8, 1'b0, 0, 1'b0);
    vecs[5]  = mk(32'h0000_0050, 2, 4'd0, 1'b1, 0, 1'b0);
    vecs[6]  = mk(32'h0000_0050, 2, 4'd9, 1'b1, 0, 1'b0);
    vecs[7]  = mk(32'h0012_5693, 3, 4'd7, 1'b1, 0, 1'b0);
`ifdef NFCA_ANTICOLL_AUTO_EN
    vecs[8]  = mk(32'h0000_2095, 2, 4'd8, 1'b1, 0, 1'b0);
`else
    vecs[8]  = mk(32'h0000_2095, 2, 4'd8, 1'b1, 0, 1'b1);
`endif
    vecs[9]  = mk(32'h3412_7095, 4, 4'd8, 1'b1, 1, 1'b1);
    vecs[10] = mk(32'h0000_0093, 1, 4'd8, 1'b1, 0, 1'b1);

    rst = 1'b1; m_tready = 1'b1;
    s_tvalid = 1'b0; s_tdata = '0; s_tdatab = '0; s_tlast = 1'b0; s_crc_en = 1'b0;
    #1;
    chk("reset_state", {m_tvalid, m_tlast, m_tdatab, m_tdata}, 14'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_tready", s_tready, 1'b1);
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Reset while the first CRC byte is pending behind a stalled slot.
    m_tready = 1'b1;
    s_tvalid = 1'b1; s_tdata = 8'h50; s_tdatab = 4'd8; s_tlast = 1'b0; s_crc_en = 1'b1;
    @(posedge clk); #1;
    s_tdata = 8'h00; s_tlast = 1'b1; s_crc_en = 1'b0;
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    @(negedge clk);
    chk("crc_lo_stall_out", {m_tvalid, m_tlast, m_tdata}, {1'b1, 1'b0, 8'h00});
    chk("crc_lo_tready", s_tready, 1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("async_rst_out", {m_tvalid, m_tlast, m_tdatab, m_tdata}, 14'h0);
    @(posedge clk); #1;
    rst = 1'b0; m_tready = 1'b1;
    @(posedge clk); #1;
    v = mk(32'h0000_0050, 2, 4'd8, 1'b1, 0, 1'b1);
    v.exp[2] = 8'h57; v.exp[3] = 8'hCD;
    run_vec(99, v);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nfca_tx_crc_append.md
NFCA_TX_CRC_APPEND -- requirements
Module: nfca_tx_crc_append

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk and rst; all state SHALL be in the clk domain.
REQ-002 clk  input  1  system clock, 81.36 MHz (6x carrier).
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 s_tvalid  input  1  upstream byte valid.
REQ-005 s_tready  output  1  block accepts the upstream byte this cycle.
REQ-006 s_tdata  input  8  frame byte, LSB transmitted first.
REQ-007 s_tdatab  input  4  valid bit count of the byte, 1..8; meaningful only when s_tlast=1, otherwise treated as 8.
REQ-008 s_tlast  input  1  last byte of the frame.
REQ-009 s_crc_en  input  1  request CRC_A append; sampled with the first byte of each frame.
REQ-010 m_tvalid, m_tready, m_tdata[7:0], m_tdatab[3:0], m_tlast  output/input/output/output/output  same meaning as s_*; drives the tx_* port of nfca_controller.

Function
REQ-011 States SHALL be DATA, CRC_LO and CRC_HI; the reset state is DATA.
REQ-012 The output SHALL be a single registered slot; the slot is free when m_tvalid=0 or m_tready=1.
REQ-013 s_tready SHALL be 1 only in DATA with a free slot.
REQ-014 An accepted byte SHALL appear on m_* in the next cycle with data and datab unchanged, for one cycle of latency.
REQ-015 CRC_A: 16-bit register, init 0x6363, reflected polynomial 0x8408, bytes processed LSB first, no final XOR; every accepted byte is included.
REQ-016 Append condition, evaluated at the last byte: the sampled s_crc_en=1 and s_tdatab=8.
REQ-017 When the append condition holds, the last byte SHALL be forwarded with m_tlast=0 and the state SHALL go to CRC_LO.
REQ-018 CRC_LO: when the slot is free, emit crc[7:0] with datab=8 and tlast=0, then go to CRC_HI.
REQ-019 CRC_HI: when the slot is free, emit crc[15:8] with datab=8 and tlast=1, then go to DATA.
REQ-020 When the append condition fails, the last byte SHALL be forwarded with m_tlast=1 and no CRC bytes follow.
REQ-021 The CRC register SHALL reload 0x6363 on entry to DATA after a frame ends; the first byte of a frame uses the init value.
REQ-022 m_* SHALL hold stable while m_tvalid=1 and m_tready=0; no byte is dropped or duplicated under back-pressure.
REQ-023 s_tready SHALL be 0 throughout CRC_LO and CRC_HI; the next frame's first byte waits.
REQ-024 s_tdatab values 0 or greater than 8 on a last byte SHALL be forwarded unchanged and SHALL suppress the append.

Reset
REQ-025 Asserting rst SHALL set the state to DATA, m_tvalid=0, m_tdata=0, m_tdatab=0, m_tlast=0 and crc=0x6363, and SHALL clear the sampled crc_en and first/second-byte tracking.
REQ-026 rst mid-frame SHALL abandon the frame; after release, the next accepted byte is treated as a frame start.

Configuration
REQ-027 Macro NFCA_ANTICOLL_AUTO_EN: when defined, the append SHALL additionally be suppressed when the frame's first byte is 0x93, 0x95 or 0x97 and its second byte (NVB) is not 0x70.
REQ-028 A single-byte frame under NFCA_ANTICOLL_AUTO_EN SHALL follow REQ-016 only.
REQ-029 When NFCA_ANTICOLL_AUTO_EN is not defined, the append SHALL depend on REQ-016 only, and the NVB-tracking logic SHALL be absent.

Verification
REQ-030 Frame {0x26}, datab=7, crc_en=1 -> output 0x26 with datab=7 and tlast=1; no CRC bytes.
REQ-031 Frame {0x50,0x00}, crc_en=1, m_tready=1 -> output 50 00 57 CD with tlast only on 0xCD; then frame {0xE0,0x50} -> E0 50 BC A5 (checks the CRC reload).
REQ-032 Frame {0x00,0x00}, crc_en=1, with m_tready toggled 1010... -> output 00 00 A0 1E in order, each byte held stable while stalled.
REQ-033 With NFCA_ANTICOLL_AUTO_EN, crc_en=1: {0x93,0x56,0x12}, datab=7 -> no CRC; {0x95,0x20} -> no CRC, tlast on 0x20; {0x95,0x70,0x12,0x34} -> two CRC bytes appended. Without the macro, {0x95,0x20} -> CRC appended.
REQ-034 rst pulsed while in CRC_LO with m_tready=0 -> m_tvalid=0 immediately, no asynchronous wait on clk; then {0x50,0x00} -> 50 00 57 CD.
